// File: rtl/fifo_mem_ctrl_pkg.sv
// Shared constants, sizing helpers and word/pointer types for the RAM-backed FIFO controller.
package fifo_mem_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_ADDR_WIDTH = 6;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Occupancy spans 0..DEPTH+2, so two bits above the address width.
    function automatic int count_width(input int addr_width);
        return addr_width + 2;
    endfunction

    localparam int DEF_DEPTH   = depth_of(DEF_ADDR_WIDTH);
    localparam int DEF_COUNT_W = count_width(DEF_ADDR_WIDTH);

    typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/fifo_mem_ctrl_if.sv
// Producer/consumer stream plus RAM port signals of the FIFO controller.
interface fifo_mem_ctrl_if
    import fifo_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH+1:0] count;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_data_in_a;
    logic                  mem_write_en_a;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [DATA_WIDTH-1:0] mem_data_out_b;

    // Controller side.
    modport slave (
        input  in_data, in_valid, out_ready, mem_data_out_b,
        output in_ready, out_data, out_valid, count,
               mem_addr_a, mem_data_in_a, mem_write_en_a, mem_addr_b
    );

    // Environment side: producer, consumer and RAM.
    modport master (
        output in_data, in_valid, out_ready, mem_data_out_b,
        input  in_ready, out_data, out_valid, count,
               mem_addr_a, mem_data_in_a, mem_write_en_a, mem_addr_b
    );
endinterface

// File: rtl/fifo_mem_ctrl_out_buf.sv
// Two-entry registered output buffer; head entry drives the consumer stream directly.
module fifo_out_buf
    import fifo_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic [1:0]            cnt
);
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (capture) begin
                        head <= din;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({capture, pop})
                        2'b11: head <= din;
                        2'b10: begin
                            tail <= din;
                            cnt  <= 2'd2;
                        end
                        2'b01: cnt <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // Issue is throttled so a capture into a full buffer only comes with a pop.
                    if (pop) begin
                        head <= tail;
                        if (capture) tail <= din;
                        else         cnt  <= 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

    assign dout  = head;
    assign valid = (cnt != 2'd0);

endmodule

// File: rtl/fifo_mem_ctrl.sv
// Ready/valid FIFO over an external simple dual-port RAM with one-cycle read latency.
module fifo_mem_ctrl
    import fifo_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    fifo_mem_ctrl_if.slave  bus
);
    localparam int                  DEPTH    = depth_of(ADDR_WIDTH);
    localparam int                  CW       = count_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  rd_pend;
    logic [1:0]            buf_cnt;
    logic [2:0]            occ;
    logic                  ready;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;

    always_comb begin
        ready = !rst && (mem_cnt != MEM_FULL);
        push  = bus.in_valid && ready;
        pop   = valid && bus.out_ready;
        occ   = {1'b0, buf_cnt} + {2'b00, rd_pend};
        // Issue only if the word will have a buffer slot when it lands next cycle.
        issue = (mem_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            rd_pend <= issue;
            case ({push, issue})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .capture (rd_pend),
        .din     (bus.mem_data_out_b),
        .pop     (pop),
        .dout    (data),
        .valid   (valid),
        .cnt     (buf_cnt)
    );

    assign bus.in_ready       = ready;
    assign bus.out_data       = data;
    assign bus.out_valid      = valid;
    assign bus.count          = CW'(mem_cnt) + CW'(rd_pend) + CW'(buf_cnt);
    assign bus.mem_addr_a     = wr_ptr;
    assign bus.mem_data_in_a  = bus.in_data;
    assign bus.mem_write_en_a = push;
    assign bus.mem_addr_b     = rd_ptr;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Randomized scoreboard bench for fifo_mem_ctrl with a behavioural RAM and queue reference model.
module tb_fifo_mem_ctrl;
    import fifo_mem_pkg::*;

    localparam int DW  = DEF_DATA_WIDTH;
    localparam int AW  = DEF_ADDR_WIDTH;
    localparam int CAP = DEF_DEPTH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM: write on port A, registered read address on port B.
    logic [DW-1:0] ram [DEF_DEPTH];
    always @(posedge clk) begin
        if (bus.mem_write_en_a) ram[bus.mem_addr_a] <= bus.mem_data_in_a;
        bus.mem_data_out_b <= ram[bus.mem_addr_b];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: the FIFO is just an ordered queue of accepted words.
    logic [DW-1:0] exp_q [$];
    int            model_cnt = 0;
    int            pops      = 0;
    bit            after_rst = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
            after_rst = 1'b1;
        end else begin
            if (after_rst) begin
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_out_data",  32'(bus.out_data),  32'd0);
                chk("rst_count",     32'(bus.count),     32'd0);
                chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
                after_rst = 1'b0;
            end else begin
                chk("count", 32'(bus.count), 32'(model_cnt));
            end
            if (model_cnt == CAP) begin
                chk("full_in_ready", 32'(bus.in_ready),       32'd0);
                chk("full_wr_en",    32'(bus.mem_write_en_a), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                bit empty;
                empty = (exp_q.size() == 0);
                chk("pop_nonempty", 32'(empty), 32'd0);
                if (!empty) chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                model_cnt--;
                pops++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(bus.in_data);
                model_cnt++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 500; k++) begin
            acc = bus.in_ready;
            cyc();
            if (acc) break;
            if (k == 499) chk("push_timeout", 32'd0, 32'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 400 && bus.count != '0; k++) cyc();
        chk("drain_done", 32'(bus.count), 32'd0);
        bus.out_ready = 1'b0;
        cyc();
    endtask

    initial begin
        int p0;
        logic [DW-1:0] seq;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;

        // Single word latency: push at edge N, visible after N+2, popped at N+3.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 14'h1A5;
        cyc();
        bus.in_valid = 1'b0;
        chk("lat_count1", 32'(bus.count), 32'd1);
        chk("lat_v0", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("lat_v1", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("lat_v2", 32'(bus.out_valid), 32'd1);
        chk("lat_data", 32'(bus.out_data), 32'h1A5);
        cyc();
        chk("lat_count0", 32'(bus.count), 32'd0);
        bus.out_ready = 1'b0;
        cyc();

        // Fill to full capacity with the consumer stalled.
        for (int i = 0; i < CAP; i++) push_word(DW'(i));
        chk("fill_count", 32'(bus.count), 32'(CAP));
        chk("fill_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 14'h0003;
        for (int i = 0; i < 4; i++) begin
            chk("full_no_write", 32'(bus.mem_write_en_a), 32'd0);
            cyc();
        end
        bus.in_valid = 1'b0;

        // One pop while RAM is full: ready stays low now, returns once the refill issues.
        bus.out_ready = 1'b1;
        chk("edge_ready_hold", 32'(bus.in_ready), 32'd0);
        cyc();
        bus.out_ready = 1'b0;
        chk("edge_ready_back", 32'(bus.in_ready), 32'd1);
        chk("edge_count", 32'(bus.count), 32'(CAP - 1));
        drain();

        // Streaming: 200 cycles of back-to-back push and pop, wrapping pointers.
        seq = 14'h0100;
        p0  = pops;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bus.in_data = seq;
            seq = seq + 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        chk("stream_rate", 32'(pops - p0 >= 197), 32'd1);
        drain();

        // Random traffic and backpressure.
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = DW'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        drain();

        // Reset with ten words stored and a read in flight.
        for (int i = 0; i < 11; i++) push_word(DW'($urandom));
        chk("mid_count11", 32'(bus.count), 32'd11);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("mid_count10", 32'(bus.count), 32'd10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        push_word(14'h3FFF);
        for (int k = 0; k < 10 && !bus.out_valid; k++) cyc();
        chk("mid_next_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_next_data", 32'(bus.out_data), 32'h3FFF);
        drain();

        chk("final_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_mem_ctrl.md
# fifo_mem_ctrl

Ready/valid FIFO controller that uses an external 64×14 simple dual-port RAM as its storage. It sits directly upstream of the RAM:
- It drives port A as the write port and port B as the read port.
- It consumes port B read data, which arrives one cycle after the address is registered.
- It presents the stream on a registered output stage.

Producer and consumer see a plain FIFO; RAM latency is hidden by a 2-entry output buffer.

## Interface
- DATA_WIDTH, 14, word width; must match RAM width
- ADDR_WIDTH, 6, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH
- clk  in  1  single clock for the block and the RAM
- rst  in  1  reset; one clock, reset is synchronous and active-high
- in_data  in  DATA_WIDTH  write payload
- in_valid  in  1  producer has data
- in_ready  out  1  block accepts data this cycle
- out_data  out  DATA_WIDTH  head-of-FIFO word, driven from a register
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer takes the word
- count  out  ADDR_WIDTH+2  total occupancy: RAM-resident + in-flight read + output buffer
- mem_addr_a  out  ADDR_WIDTH  RAM port A address (write pointer)
- mem_data_in_a  out  DATA_WIDTH  equals in_data
- mem_write_en_a  out  1  in_valid & in_ready
- mem_addr_b  out  ADDR_WIDTH  RAM port B read address (read pointer); RAM registers it each clk
- mem_data_out_b  in  DATA_WIDTH  RAM port B data; valid the cycle after mem_addr_b is registered

## Operation
- **Push:** asserted when in_valid & in_ready.
  - RAM is written at wr_ptr; wr_ptr increments mod DEPTH.
  - mem_cnt (0..DEPTH) increments.
- **in_ready:** equals !rst & (mem_cnt != DEPTH). It is not gated by out_ready, and it has no combinational path from out_* signals.
- **Read issue:** asserted when mem_cnt != 0 and (buf_cnt + rd_pend − pop) < 2, where pop = out_valid & out_ready.
  - rd_ptr advances, mem_cnt decrements, and rd_pend is set for the next cycle.
  - mem_addr_b always shows rd_ptr.
- **Capture:** when rd_pend = 1, mem_data_out_b is written into the output buffer at that cycle's clock edge.
- **Output buffer:** a 2-entry FIFO.
  - out_data and out_valid are the buffer head; out_valid = (buf_cnt != 0).
  - A capture and a pop in the same cycle are both honoured.
- **Simultaneous push and issue:** mem_cnt is unchanged. wr_ptr and rd_ptr never alias an occupied slot, so there is no RAM read/write collision handling.
- **Wrap-around:** pointers are plain ADDR_WIDTH-bit counters and wrap DEPTH−1 → 0. Full and empty are decided by mem_cnt, not by pointer comparison.
- **Total capacity:** DEPTH + 2 words.
- **Reset (including mid-operation):**
  - wr_ptr = rd_ptr = 0; mem_cnt = buf_cnt = 0; rd_pend = 0.
  - Any in-flight read is discarded.
  - RAM contents are not cleared.
- **Output values during and after reset:** out_valid = 0, out_data = 0, count = 0, mem_write_en_a = 0, in_ready = 0 while rst is high and 1 on the first cycle after.

## Timing
- **Push-to-output latency, empty FIFO:** push accepted at edge N → read issued in cycle N..N+1 (addr registered at N+1) → captured at N+2. out_valid is first high after edge N+2, a latency of 2 cycles.
- **Throughput:** 1 word/cycle sustained with out_ready held high.
- **Backpressure:** out_ready low stops issue once buf_cnt + rd_pend = 2. Data is never dropped or duplicated.
- **count update:** count updates on the edge at which the event occurs.
- **Combinational paths:** none from inputs to out_valid, out_data or in_ready. Only mem_write_en_a and mem_data_in_a follow in_* combinationally.

## Structure
- **Package fifo_mem_pkg:**
  - DEPTH derivation function
  - count width constant
  - typedefs for ptr_t (ADDR_WIDTH) and word_t (DATA_WIDTH)
- **Sub-module fifo_out_buf:** the 2-entry output buffer (capture/pop/data/valid, buf_cnt), instantiated once.
- **Top level:** holds the pointers, mem_cnt, rd_pend and the issue logic.

## Test plan
- **Reset, then single word:** release rst; push 14'h1A5 at edge N with out_ready = 1 → out_valid rises after edge N+2 with out_data = 14'h1A5, popped at the next edge; count goes 0 → 1 → 0.
- **Fill to full:** hold out_ready = 0 and push 0..65 → in_ready drops after the 64th RAM-resident word, while count reaches 66. Push attempts while full cause no RAM write and no count change. Draining then returns 0..65 in order.
- **Streaming with wrap:** in_valid = out_ready = 1 for 200 cycles with an incrementing pattern → pointers wrap ≥3 times. The output matches input order, and after fill the rate is one word per cycle.
- **Random backpressure:** random in_valid and out_ready at 50% each for 2000 cycles → scoreboard shows no loss or duplication, and count always equals pushes − pops.
- **Reset mid-operation:** with count = 10 and a read in flight, assert rst for one cycle → out_valid = 0 and count = 0. A subsequent push of 14'h3FFF is the next word out; no stale data appears.
- **Empty/full edges together:** hold the FIFO at mem_cnt = DEPTH while the consumer pops one word → in_ready stays 0 in that cycle and returns to 1 once the refill read has issued.
